// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE microcode front end: fetch FSM states, CCE mode,
// and the raw instruction width the decoder expects.
`ifndef BP_CCE_INST_WIDTH
`define BP_CCE_INST_WIDTH 48
`endif

package bp_cce_pkg;

  localparam int cce_inst_width_gp = `BP_CCE_INST_WIDTH;

  typedef enum logic [1:0] {
    e_fetch_reset = 2'd0,
    e_fetch_init  = 2'd1,
    e_fetch_run   = 2'd2
  } bp_cce_fetch_state_e;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

endpackage

// File: rtl/bp_cce_inst_ram.sv
// Instruction RAM with its single port shared between the config link and
// the fetch path; config takes the port whenever it is active.
module bp_cce_inst_ram #(
  parameter int num_els_p = 256,
  parameter int width_p   = 48,
  localparam int lg_els_lp = $clog2(num_els_p)
) (
  input  logic                 clk_i,
  input  logic                 cfg_v_i,
  input  logic                 cfg_w_i,
  input  logic [lg_els_lp-1:0] cfg_addr_i,
  input  logic [width_p-1:0]   cfg_data_i,
  input  logic                 fetch_v_i,
  input  logic [lg_els_lp-1:0] fetch_addr_i,
  output logic [width_p-1:0]   data_o
);

  logic                 v_li, w_li;
  logic [lg_els_lp-1:0] addr_li;

  assign v_li    = cfg_v_i | fetch_v_i;
  assign w_li    = cfg_v_i & cfg_w_i;
  assign addr_li = cfg_v_i ? cfg_addr_i : fetch_addr_i;

  bsg_mem_1rw_sync #(
    .width_p(width_p),
    .els_p  (num_els_p)
  ) mem (
    .clk_i (clk_i),
    .v_i   (v_li),
    .w_i   (w_li),
    .addr_i(addr_li),
    .data_i(cfg_data_i),
    .data_o(data_o)
  );

endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one read or one write per cycle, read data
// appears the cycle after the access and holds until the next read.
module bsg_mem_1rw_sync #(
  parameter int width_p = 48,
  parameter int els_p   = 256,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) mem_r[addr_i] <= data_i;
      else     data_o        <= mem_r[addr_i];
    end
  end

endmodule

// File: rtl/bp_cce_fetch.sv
// CCE microcode fetch: loads the instruction RAM over config in init, then
// streams one instruction per cycle with fall-through prediction.
module bp_cce_fetch
  import bp_cce_pkg::*;
#(
  parameter int num_cce_instr_ram_els_p = 256,
  parameter int cce_instr_width_p       = cce_inst_width_gp,
  localparam int lg_num_instr_lp        = $clog2(num_cce_instr_ram_els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  bp_cce_mode_e                 cce_mode_i,
  input  logic                         cfg_w_v_i,
  input  logic                         cfg_r_v_i,
  input  logic [lg_num_instr_lp-1:0]   cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic                         cfg_r_v_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,
  input  logic                         stall_i,
  input  logic                         redirect_v_i,
  input  logic [lg_num_instr_lp-1:0]   redirect_pc_i,
  output logic                         inst_v_o,
  output logic [cce_instr_width_p-1:0] inst_o,
  output logic [lg_num_instr_lp-1:0]   pc_o
);

  bp_cce_fetch_state_e          state_r;
  logic [lg_num_instr_lp-1:0]   fetch_pc_r, next_pc;
  logic                         inst_v_r, cfg_r_v_r;
  logic                         in_init, in_run, cfg_w, cfg_r, init_exit;
  logic [cce_instr_width_p-1:0] ram_data;

  assign in_init   = (state_r == e_fetch_init);
  assign in_run    = (state_r == e_fetch_run);
  assign cfg_w     = in_init & cfg_w_v_i;
  assign cfg_r     = in_init & cfg_r_v_i & ~cfg_w_v_i;
  assign init_exit = in_init & (cce_mode_i == e_cce_mode_normal) & ~cfg_w_v_i & ~cfg_r_v_i;

  // A bubble (inst_v_r low) re-reads the pending redirect target instead of
  // falling through, so the target itself is the next valid instruction.
  always_comb begin
    next_pc = fetch_pc_r + lg_num_instr_lp'(1);
    if (redirect_v_i)            next_pc = redirect_pc_i;
    else if (stall_i | ~inst_v_r) next_pc = fetch_pc_r;
  end

  bp_cce_inst_ram #(
    .num_els_p(num_cce_instr_ram_els_p),
    .width_p  (cce_instr_width_p)
  ) inst_ram (
    .clk_i       (clk_i),
    .cfg_v_i     (cfg_w | cfg_r),
    .cfg_w_i     (cfg_w),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_i  (cfg_data_i),
    .fetch_v_i   (init_exit | in_run),
    .fetch_addr_i(init_exit ? '0 : next_pc),
    .data_o      (ram_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_fetch_reset;
      fetch_pc_r <= '0;
      inst_v_r   <= 1'b0;
      cfg_r_v_r  <= 1'b0;
    end else begin
      cfg_r_v_r <= 1'b0;
      case (state_r)
        e_fetch_reset: state_r <= e_fetch_init;
        e_fetch_init: begin
          cfg_r_v_r <= cfg_r;
          if (init_exit) begin
            state_r    <= e_fetch_run;
            fetch_pc_r <= '0;
            inst_v_r   <= 1'b1;
          end
        end
        e_fetch_run: begin
          fetch_pc_r <= next_pc;
          if (redirect_v_i) inst_v_r <= 1'b0;
          else if (!stall_i) inst_v_r <= 1'b1;
        end
        default: state_r <= e_fetch_reset;
      endcase
    end
  end

  assign cfg_ready_o = in_init;
  assign cfg_r_v_o   = cfg_r_v_r;
  assign cfg_data_o  = ram_data;
  assign inst_v_o    = inst_v_r;
  assign inst_o      = ram_data;
  assign pc_o        = fetch_pc_r;

endmodule

// File: tb/tb_bp_cce_fetch.sv
// Directed bench for the CCE fetch front end: config load/read, fetch start,
// stall, redirect, wrap, run-mode config rejection and reset preservation.
module tb_bp_cce_fetch;
  import bp_cce_pkg::*;

  logic         clk = 1'b0;
  logic         reset_i;
  bp_cce_mode_e cce_mode_i;
  logic         cfg_w_v_i, cfg_r_v_i;
  logic [7:0]   cfg_addr_i;
  logic [47:0]  cfg_data_i;
  logic         cfg_ready_o, cfg_r_v_o;
  logic [47:0]  cfg_data_o;
  logic         stall_i, redirect_v_i;
  logic [7:0]   redirect_pc_i;
  logic         inst_v_o;
  logic [47:0]  inst_o;
  logic [7:0]   pc_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_cce_fetch #(.num_cce_instr_ram_els_p(256), .cce_instr_width_p(48)) dut (
    .clk_i(clk), .reset_i(reset_i), .cce_mode_i(cce_mode_i),
    .cfg_w_v_i(cfg_w_v_i), .cfg_r_v_i(cfg_r_v_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_ready_o(cfg_ready_o), .cfg_r_v_o(cfg_r_v_o),
    .cfg_data_o(cfg_data_o), .stall_i(stall_i), .redirect_v_i(redirect_v_i),
    .redirect_pc_i(redirect_pc_i), .inst_v_o(inst_v_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [47:0] d);
    cfg_w_v_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    step();
    cfg_w_v_i = 1'b0;
  endtask

  task automatic redirect_to(input logic [7:0] a);
    redirect_v_i = 1'b1; redirect_pc_i = a;
    step();
    redirect_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; step(); step();
    checks++; if ({inst_v_o, cfg_ready_o, cfg_r_v_o} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {inst_v_o, cfg_ready_o, cfg_r_v_o}); end
    checks++; if (pc_o !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc_o); end
    reset_i = 1'b0; step();
    checks++; if ({cfg_ready_o, inst_v_o} !== 2'b10) begin
      failures++; $display("FAIL init_ready got=%b exp=10", {cfg_ready_o, inst_v_o}); end
  endtask

  task automatic test_cfg();
    for (int i = 0; i < 4; i++) cfg_write(8'(i), 48'h10 + 48'(i));
    cfg_r_v_i = 1'b1; cfg_addr_i = 8'd2; step(); cfg_r_v_i = 1'b0;
    checks++; if (cfg_r_v_o !== 1'b1 || cfg_data_o !== 48'h12) begin
      failures++; $display("FAIL cfg_read2 got v=%b d=%0h exp v=1 d=12", cfg_r_v_o, cfg_data_o); end
    checks++; if (inst_v_o !== 1'b0) begin failures++; $display("FAIL init_inst_v got=%b exp=0", inst_v_o); end
    step();
    checks++; if (cfg_r_v_o !== 1'b0) begin failures++; $display("FAIL cfg_r_v_drop got=%b exp=0", cfg_r_v_o); end
    cfg_w_v_i = 1'b1; cfg_r_v_i = 1'b1; cfg_addr_i = 8'd5; cfg_data_i = 48'h55; step();
    cfg_w_v_i = 1'b0; cfg_r_v_i = 1'b0;
    checks++; if (cfg_r_v_o !== 1'b0) begin failures++; $display("FAIL cfg_wr_collide got=%b exp=0", cfg_r_v_o); end
    cfg_r_v_i = 1'b1; cfg_addr_i = 8'd5; step(); cfg_r_v_i = 1'b0;
    checks++; if (cfg_r_v_o !== 1'b1 || cfg_data_o !== 48'h55) begin
      failures++; $display("FAIL cfg_read5 got v=%b d=%0h exp v=1 d=55", cfg_r_v_o, cfg_data_o); end
  endtask

  task automatic test_fetch_start();
    cce_mode_i = e_cce_mode_normal; step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd0, 48'h10}) begin
      failures++; $display("FAIL fetch_first got v=%b pc=%0d i=%0h exp v=1 pc=0 i=10", inst_v_o, pc_o, inst_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd1, 48'h11}) begin
      failures++; $display("FAIL fetch_pc1 got v=%b pc=%0d i=%0h exp v=1 pc=1 i=11", inst_v_o, pc_o, inst_o); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd1, 48'h11}) begin
        failures++; $display("FAIL stall_hold%0d got v=%b pc=%0d i=%0h exp v=1 pc=1 i=11", i, inst_v_o, pc_o, inst_o); end
    end
    stall_i = 1'b0; step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd2, 48'h12}) begin
      failures++; $display("FAIL stall_release got v=%b pc=%0d i=%0h exp v=1 pc=2 i=12", inst_v_o, pc_o, inst_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd3, 48'h13}) begin
      failures++; $display("FAIL fetch_pc3 got v=%b pc=%0d i=%0h exp v=1 pc=3 i=13", inst_v_o, pc_o, inst_o); end
  endtask

  task automatic test_redirect();
    redirect_to(8'd0);
    checks++; if (inst_v_o !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", inst_v_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd0, 48'h10}) begin
      failures++; $display("FAIL redir_target got v=%b pc=%0d i=%0h exp v=1 pc=0 i=10", inst_v_o, pc_o, inst_o); end
    stall_i = 1'b1; redirect_to(8'd2); stall_i = 1'b0;
    checks++; if (inst_v_o !== 1'b0) begin failures++; $display("FAIL redir_stall_bubble got=%b exp=0", inst_v_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd2, 48'h12}) begin
      failures++; $display("FAIL redir_stall_target got v=%b pc=%0d i=%0h exp v=1 pc=2 i=12", inst_v_o, pc_o, inst_o); end
    redirect_to(8'd1); redirect_to(8'd3);
    checks++; if (inst_v_o !== 1'b0) begin failures++; $display("FAIL redir_in_bubble got=%b exp=0", inst_v_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd3, 48'h13}) begin
      failures++; $display("FAIL redir_latest got v=%b pc=%0d i=%0h exp v=1 pc=3 i=13", inst_v_o, pc_o, inst_o); end
    redirect_to(8'd1); stall_i = 1'b1; step();
    checks++; if (inst_v_o !== 1'b0) begin failures++; $display("FAIL stall_keeps_bubble got=%b exp=0", inst_v_o); end
    stall_i = 1'b0; step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd1, 48'h11}) begin
      failures++; $display("FAIL bubble_pending got v=%b pc=%0d i=%0h exp v=1 pc=1 i=11", inst_v_o, pc_o, inst_o); end
  endtask

  task automatic test_wrap();
    cce_mode_i = e_cce_mode_uncached;
    reset_i = 1'b1; step(); reset_i = 1'b0; step();
    cfg_write(8'd255, 48'hFF);
    cce_mode_i = e_cce_mode_normal; step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd0, 48'h10}) begin
      failures++; $display("FAIL reload_first got v=%b pc=%0d i=%0h exp v=1 pc=0 i=10", inst_v_o, pc_o, inst_o); end
    redirect_to(8'd255); step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd255, 48'hFF}) begin
      failures++; $display("FAIL pc_max got v=%b pc=%0d i=%0h exp v=1 pc=255 i=ff", inst_v_o, pc_o, inst_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd0, 48'h10}) begin
      failures++; $display("FAIL pc_wrap got v=%b pc=%0d i=%0h exp v=1 pc=0 i=10", inst_v_o, pc_o, inst_o); end
  endtask

  task automatic test_run_cfg();
    checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL run_ready got=%b exp=0", cfg_ready_o); end
    cce_mode_i = e_cce_mode_uncached;
    cfg_write(8'd0, 48'hAA);
    cfg_r_v_i = 1'b1; cfg_addr_i = 8'd0; step(); cfg_r_v_i = 1'b0;
    checks++; if ({cfg_r_v_o, inst_v_o} !== 2'b01) begin
      failures++; $display("FAIL run_cfg_ignored got r_v,inst_v=%b exp=01", {cfg_r_v_o, inst_v_o}); end
    redirect_to(8'd0); step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd0, 48'h10}) begin
      failures++; $display("FAIL run_no_write got v=%b pc=%0d i=%0h exp v=1 pc=0 i=10", inst_v_o, pc_o, inst_o); end
  endtask

  task automatic test_reset_midrun();
    reset_i = 1'b1; step();
    checks++; if ({inst_v_o, cfg_ready_o, pc_o} !== {1'b0, 1'b0, 8'd0}) begin
      failures++; $display("FAIL midrun_reset got v=%b rdy=%b pc=%0d exp v=0 rdy=0 pc=0", inst_v_o, cfg_ready_o, pc_o); end
    reset_i = 1'b0; step();
    checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL midrun_init got=%b exp=1", cfg_ready_o); end
    cce_mode_i = e_cce_mode_normal; step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd0, 48'h10}) begin
      failures++; $display("FAIL midrun_preserve got v=%b pc=%0d i=%0h exp v=1 pc=0 i=10", inst_v_o, pc_o, inst_o); end
    step();
    checks++; if ({inst_v_o, pc_o, inst_o} !== {1'b1, 8'd1, 48'h11}) begin
      failures++; $display("FAIL midrun_pc1 got v=%b pc=%0d i=%0h exp v=1 pc=1 i=11", inst_v_o, pc_o, inst_o); end
  endtask

  initial begin
    reset_i = 1'b1; cce_mode_i = e_cce_mode_uncached;
    cfg_w_v_i = 1'b0; cfg_r_v_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    stall_i = 1'b0; redirect_v_i = 1'b0; redirect_pc_i = '0;
    test_reset();
    test_cfg();
    test_fetch_start();
    test_stall();
    test_redirect();
    test_wrap();
    test_run_cfg();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_cce_fetch.md
Name: bp_cce_fetch

Overview:
- Microcode front end of the CCE: holds the instruction RAM and program counter, and feeds one raw instruction per cycle to the decoder.
- The decoder's output drives the CCE register stage and the rest of the CCE datapath.
- The RAM is loaded over the config link while the CCE is in uncached mode.
- Fetch predicts fall-through (PC+1). Branch/stall logic downstream supplies stall and redirect.

Parameters:
num_cce_instr_ram_els_p, 256, instruction RAM depth; power of two.
cce_instr_width_p, 48, raw microcode instruction width.
lg_num_instr_lp (localparam), clog2(num_cce_instr_ram_els_p), PC width.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
cce_mode_i  in  bp_cce_mode_e  e_cce_mode_uncached / e_cce_mode_normal
cfg_w_v_i  in  1  config write valid
cfg_r_v_i  in  1  config read valid
cfg_addr_i  in  lg_num_instr_lp  RAM address for config access
cfg_data_i  in  cce_instr_width_p  config write data
cfg_ready_o  out  1  config access accepted this cycle
cfg_r_v_o  out  1  read data valid; one cycle after accepted read
cfg_data_o  out  cce_instr_width_p  config read data
stall_i  in  1  decoder/ucode stall; hold current instruction
redirect_v_i  in  1  branch mispredict / jump; redirect fetch
redirect_pc_i  in  lg_num_instr_lp  redirect target
inst_v_o  out  1  inst_o valid
inst_o  out  cce_instr_width_p  raw instruction
pc_o  out  lg_num_instr_lp  PC of inst_o

Behaviour:
- FSM states are e_fetch_reset, e_fetch_init, e_fetch_run.
- Reset values: state=e_fetch_reset, fetch_pc_r=0, inst_v_o=0, cfg_r_v_o=0, cfg_ready_o=0.
- pc_o=0 during reset. inst_o/cfg_data_o are don't-care when not valid.
- e_fetch_reset lasts exactly one cycle after reset deasserts, then goes to e_fetch_init.
- e_fetch_init:
  - cfg_ready_o=1 and inst_v_o=0.
  - Write: cfg_w_v_i writes cfg_data_i to RAM[cfg_addr_i].
  - Read: cfg_r_v_i reads RAM, giving cfg_r_v_o=1 and data next cycle.
  - Simultaneous w and r in the same cycle: the write wins and the read is dropped (cfg_r_v_o stays 0).
  - Exit to e_fetch_run when cce_mode_i==e_cce_mode_normal and neither cfg_w_v_i nor cfg_r_v_i is high. On the exit cycle the RAM reads address 0 and fetch_pc_r is set to 0.
- e_fetch_run:
  - cfg_ready_o=0. Config requests are ignored: no RAM access, no cfg_r_v_o.
  - Stays in run until reset; mode changes are ignored.
- Latency: the RAM is 1rw synchronous. The first cycle in run has inst_v_o=1, inst_o=RAM[0], pc_o=0.
- Next read address, by priority:
  1. redirect_v_i: redirect_pc_i.
  2. stall_i: pc_o (re-read, so outputs hold).
  3. Otherwise: pc_o+1, modulo num_cce_instr_ram_els_p (wrap from max to 0).
- Redirect:
  - Cycle after redirect_v_i, inst_v_o=0 (bubble; squashes the fall-through fetch).
  - Cycle after that, inst_o=RAM[redirect_pc_i] with pc_o=redirect_pc_i, valid.
  - Redirect wins over a simultaneous stall.
  - Redirect during a bubble cycle is legal; the latest target wins.
- Stall:
  - While stall_i=1 and not redirecting, inst_o/pc_o/inst_v_o hold their values.
  - A stall during a bubble keeps the bubble and keeps the pending address.
- fetch_pc_r tracks the address issued to the RAM. pc_o is registered fetch_pc_r.
- A RAM write never occurs in run, so there is no read/write hazard.
- Reset mid-run returns to e_fetch_reset. RAM contents are preserved (no clear), so the ucode need not be reloaded.

Decomposition:
- bp_cce_pkg:
  - bp_cce_fetch_state_e.
  - bp_cce_mode_e, if not already present.
  - `bp_cce_inst_width constant tying cce_instr_width_p to the decoder.
- Sub-module bp_cce_inst_ram: a thin wrapper over bsg_mem_1rw_sync, with the single port muxed between config and fetch.
- FSM, PC select and the output register stay in bp_cce_fetch.

Test Plan:
1. Reset, then in init write RAM[0..3]=0x10,0x11,0x12,0x13, then read addr 2 -> cfg_r_v_o=1 with cfg_data_o=0x12 one cycle later; inst_v_o stays 0.
2. Switch cce_mode_i to normal with no cfg traffic -> next cycle pc_o=0, inst_o=0x10; then pc 1,2,3 on consecutive cycles.
3. stall_i high for 3 cycles while pc_o=1 -> inst_o=0x11 and pc_o=1 held; after release pc_o=2 next cycle.
4. redirect_v_i with redirect_pc_i=0 while pc_o=3 -> next cycle inst_v_o=0, then pc_o=0 with inst_o=0x10; redirect+stall in the same cycle gives the same result.
5. Load RAM[255]=0xFF, redirect to 255 -> pc_o=255, then wraps to pc_o=0.
6. In run, cfg_w_v_i to addr 0 with 0xAA -> cfg_ready_o=0, and RAM[0] still 0x10 on a later redirect to 0. Assert reset mid-run, reenter normal -> pc_o=0 with contents intact.
